// File: rtl/hex_overlay_if.sv
// Signal bundle between the hex overlay sequencer and its video timing, font ROM and mixer neighbours.
// The master modport is the sequencer side; the slave modport is the environment driving it.
interface hex_overlay_if #(
  parameter int DIGITS = 8
);
  logic                  pixel_en;
  logic [9:0]            hcount;
  logic [9:0]            vcount;
  logic                  vblank;
  logic [4*DIGITS-1:0]   value;
  logic [5:0]            font_char;
  logic [2:0]            font_row;
  logic [7:0]            font_data;
  logic                  ov_active;
  logic                  ov_ink;

  modport master (
    input  pixel_en, hcount, vcount, vblank, value, font_data,
    output font_char, font_row, ov_active, ov_ink
  );

  modport slave (
    output pixel_en, hcount, vcount, vblank, value, font_data,
    input  font_char, font_row, ov_active, ov_ink
  );
endinterface

// File: rtl/hex_overlay_ctrl.sv
// Overlays a frame-stable hex value on the video stream by fetching one font row per digit
// one pixel ahead of the digit and serialising it into a per-pixel ink flag.
module hex_overlay_ctrl #(
  parameter int DIGITS = 8,
  parameter int X0     = 16,
  parameter int Y0     = 8
) (
  input  logic          clk,
  input  logic          reset,
  hex_overlay_if.master bus
);
  localparam int              DW          = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [9:0]      FETCH_COL   = 10'(X0 - 1);
  localparam logic [9:0]      Y_FIRST     = 10'(Y0);
  localparam logic [9:0]      Y_LAST      = 10'(Y0 + 7);
  localparam logic [DW-1:0]   LAST_DIGIT  = DW'(DIGITS - 1);
  // With X0 == 1 the first fetch column is the first pixel of the line, so there is no arming pixel.
  localparam bit              ARM_AT_ZERO = (X0 == 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  state_t              state_reg, state_next;
  logic [DW-1:0]       d_reg, d_next;
  logic [2:0]          b_reg, b_next;
  logic [7:0]          sr_reg, sr_next;
  logic [2:0]          row_reg, row_next;
  logic                active_reg, active_next;
  logic                ink_reg, ink_next;
  logic [5:0]          font_char_reg;
  logic [2:0]          font_row_reg;
  logic [4*DIGITS-1:0] shadow_reg;
  logic                vblank_q_reg;

  logic                fetch;
  logic                fetch_live;
  logic [DW-1:0]       fetch_digit;
  logic [2:0]          fetch_row;
  logic [5:0]          fetch_char;
  logic                line_ok;
  logic [2:0]          cur_row;
  logic [3:0]          nib [2**DW];

  // Most significant nibble is digit 0 (leftmost on screen).
  for (genvar gi = 0; gi < 2**DW; gi++) begin : g_nib
    if (gi < DIGITS) begin : g_real
      assign nib[gi] = shadow_reg[4*(DIGITS-1-gi) +: 4];
    end else begin : g_pad
      assign nib[gi] = 4'd0;
    end
  end

  assign line_ok    = (bus.vcount >= Y_FIRST) && (bus.vcount <= Y_LAST);
  assign cur_row    = 3'(bus.vcount - Y_FIRST);
  assign fetch_live = fetch && !reset;
  assign fetch_char = {2'b00, nib[fetch_digit]};

  always_comb begin
    state_next  = state_reg;
    d_next      = d_reg;
    b_next      = b_reg;
    sr_next     = sr_reg;
    row_next    = row_reg;
    active_next = active_reg;
    ink_next    = ink_reg;
    fetch       = 1'b0;
    fetch_digit = '0;
    fetch_row   = row_reg;
    if (bus.pixel_en) begin
      active_next = 1'b0;
      ink_next    = 1'b0;
      unique case (state_reg)
        IDLE: begin
          d_next = '0;
          b_next = '0;
          if (line_ok) begin
            if (ARM_AT_ZERO && bus.hcount == 10'd0) begin
              fetch      = 1'b1;
              fetch_row  = cur_row;
              row_next   = cur_row;
              state_next = SHIFT;
            end else if (bus.hcount < FETCH_COL) begin
              row_next   = cur_row;
              state_next = ARMED;
            end
          end
        end
        ARMED: begin
          if (bus.hcount == FETCH_COL) begin
            fetch      = 1'b1;
            b_next     = '0;
            state_next = SHIFT;
          end else if (bus.hcount > FETCH_COL) begin
            state_next = IDLE;
          end
        end
        SHIFT: begin
          active_next = 1'b1;
          ink_next    = ~sr_reg[7];
          sr_next     = {sr_reg[6:0], 1'b1};
          b_next      = b_reg + 3'd1;
          if (b_reg == 3'd7) begin
            if (d_reg == LAST_DIGIT) begin
              d_next     = '0;
              state_next = IDLE;
            end else begin
              fetch       = 1'b1;
              fetch_digit = d_reg + 1'b1;
              d_next      = d_reg + 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
      if (fetch) sr_next = bus.font_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      d_reg         <= '0;
      b_reg         <= '0;
      sr_reg        <= '1;
      row_reg       <= '0;
      active_reg    <= 1'b0;
      ink_reg       <= 1'b0;
      font_char_reg <= '0;
      font_row_reg  <= '0;
      shadow_reg    <= '0;
      vblank_q_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      d_reg        <= d_next;
      b_reg        <= b_next;
      sr_reg       <= sr_next;
      row_reg      <= row_next;
      active_reg   <= active_next;
      ink_reg      <= ink_next;
      vblank_q_reg <= bus.vblank;
      if (bus.vblank && !vblank_q_reg) shadow_reg <= bus.value;
      if (fetch) begin
        font_char_reg <= fetch_char;
        font_row_reg  <= fetch_row;
      end
    end
  end

  // The font ROM is combinational, so the fetch address must be visible in the fetch clk itself.
  assign bus.font_char = fetch_live ? fetch_char : font_char_reg;
  assign bus.font_row  = fetch_live ? fetch_row  : font_row_reg;
  assign bus.ov_active = active_reg;
  assign bus.ov_ink    = ink_reg;
endmodule

// File: tb/tb_hex_overlay_ctrl.sv
// Raster-driven randomized bench for two overlay configurations (8 digits at X0=16, 1 digit at X0=1)
// checked against a pixel-level reference model of the overlay rules.
module tb_hex_overlay_ctrl;
  localparam int HTOT      = 88;
  localparam int VTOT      = 22;
  localparam int VBL_START = 19;
  localparam int Y0        = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        vblank;
  logic [31:0] value_a;
  logic [3:0]  value_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_overlay_if #(.DIGITS(8)) if_a ();
  hex_overlay_if #(.DIGITS(1)) if_b ();

  hex_overlay_ctrl #(.DIGITS(8), .X0(16), .Y0(Y0)) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));
  hex_overlay_ctrl #(.DIGITS(1), .X0(1),  .Y0(Y0)) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));

  function automatic logic [7:0] font_fn(input logic [5:0] c, input logic [2:0] r);
    if (c == 6'd0 && r == 3'd2) return 8'b10011001;
    return 8'((c * 37) ^ (r * 91) ^ 8'h5A);
  endfunction

  function automatic int digits_of(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  function automatic int x0_of(input int i);
    return (i == 0) ? 16 : 1;
  endfunction

  function automatic logic [3:0] nib_of(input logic [31:0] sh, input int nd, input int k);
    return 4'(sh >> (4 * (nd - 1 - k)));
  endfunction

  assign if_a.pixel_en  = pixel_en;
  assign if_a.hcount    = hcount;
  assign if_a.vcount    = vcount;
  assign if_a.vblank    = vblank;
  assign if_a.value     = value_a;
  assign if_a.font_data = font_fn(if_a.font_char, if_a.font_row);
  assign if_b.pixel_en  = pixel_en;
  assign if_b.hcount    = hcount;
  assign if_b.vcount    = vcount;
  assign if_b.vblank    = vblank;
  assign if_b.value     = value_b;
  assign if_b.font_data = font_fn(if_b.font_char, if_b.font_row);

  logic       o_act [2];
  logic       o_ink [2];
  logic [5:0] o_fc  [2];
  logic [2:0] o_fr  [2];
  assign o_act[0] = if_a.ov_active;  assign o_act[1] = if_b.ov_active;
  assign o_ink[0] = if_a.ov_ink;     assign o_ink[1] = if_b.ov_ink;
  assign o_fc[0]  = if_a.font_char;  assign o_fc[1]  = if_b.font_char;
  assign o_fr[0]  = if_a.font_row;   assign o_fr[1]  = if_b.font_row;

  // Reference model state: what each overlay should look like, by line and by digit.
  bit          m_line_ok [2];
  logic [2:0]  m_row     [2];
  logic [31:0] m_shadow  [2];
  logic [5:0]  m_fc      [2];
  logic [2:0]  m_fr      [2];
  logic [7:0]  m_glyph   [2][8];
  logic        m_act     [2];
  logic        m_ink     [2];
  logic        m_vbq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit pen, input int h, input int v);
    bit         fetch [2];
    int         k     [2];
    logic [5:0] exp_fc;
    logic [2:0] exp_fr;
    reset    = rst;
    pixel_en = pen;
    hcount   = pen ? 10'(h) : 10'($urandom_range(0, 1023));
    vcount   = 10'(v);
    vblank   = (v >= VBL_START);
    for (int i = 0; i < 2; i++) begin
      int x0 = x0_of(i);
      int nd = digits_of(i);
      if (pen && !rst && h == 0) begin
        m_line_ok[i] = (v >= Y0) && (v < Y0 + 8);
        m_row[i]     = 3'(v - Y0);
      end
      fetch[i] = pen && !rst && m_line_ok[i] && (h + 1 >= x0) && (h + 1 < x0 + 8 * nd)
                 && ((h + 1 - x0) % 8 == 0);
      k[i] = (h + 1 - x0) / 8;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_fc = fetch[i] ? {2'b00, nib_of(m_shadow[i], digits_of(i), k[i])} : m_fc[i];
      exp_fr = fetch[i] ? m_row[i] : m_fr[i];
      check_eq($sformatf("font_char[%0d] h=%0d v=%0d", i, h, v), 32'(o_fc[i]), 32'(exp_fc));
      check_eq($sformatf("font_row[%0d] h=%0d v=%0d", i, h, v), 32'(o_fr[i]), 32'(exp_fr));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_line_ok[i] = 0;
        m_shadow[i]  = '0;
        m_fc[i]      = '0;
        m_fr[i]      = '0;
        m_act[i]     = 1'b0;
        m_ink[i]     = 1'b0;
      end else begin
        if (fetch[i]) begin
          m_fc[i]          = {2'b00, nib_of(m_shadow[i], digits_of(i), k[i])};
          m_fr[i]          = m_row[i];
          m_glyph[i][k[i]] = font_fn(m_fc[i], m_row[i]);
        end
        if (pen) begin
          int rel = h - x0_of(i);
          if (m_line_ok[i] && rel >= 0 && rel < 8 * digits_of(i)) begin
            m_act[i] = 1'b1;
            m_ink[i] = ~m_glyph[i][rel / 8][7 - (rel % 8)];
          end else begin
            m_act[i] = 1'b0;
            m_ink[i] = 1'b0;
          end
        end
      end
    end
    if (rst) begin
      m_vbq = 1'b0;
    end else begin
      if (vblank && !m_vbq) begin
        m_shadow[0] = value_a;
        m_shadow[1] = 32'(value_b);
      end
      m_vbq = vblank;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("ov_active[%0d] h=%0d v=%0d", i, h, v), 32'(o_act[i]), 32'(m_act[i]));
      check_eq($sformatf("ov_ink[%0d] h=%0d v=%0d", i, h, v), 32'(o_ink[i]), 32'(m_ink[i]));
    end
  endtask

  initial begin
    int          hc, vc, frame, mode, gaps, vi;
    logic [31:0] vals [2];
    vals[0] = 32'h11111111;
    vals[1] = 32'h22222222;
    value_a = 32'h0123ABCD;
    value_b = 4'hF;
    m_vbq   = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_line_ok[i] = 0; m_row[i] = '0; m_shadow[i] = '0; m_fc[i] = '0; m_fr[i] = '0;
      m_act[i] = 1'b0; m_ink[i] = 1'b0;
      for (int j = 0; j < 8; j++) m_glyph[i][j] = 8'hFF;
    end
    hc = 0; vc = VTOT - 2; frame = 0; vi = 0;
    repeat (3) cycle(1'b1, 1'b0, 0, vc);
    while (frame < 6) begin
      mode = frame % 3;
      gaps = (mode == 0) ? 0 : (mode == 1) ? 3 : $urandom_range(0, 2);
      repeat (gaps) cycle(1'b0, 1'b0, hc, vc);
      if (hc == 0 && vc == 12) begin
        value_a = (vi < 2) ? vals[vi] : 32'($urandom);
        value_b = 4'($urandom_range(0, 15));
        vi++;
      end
      cycle(frame == 3 && vc == Y0 + 3 && hc == 36, 1'b1, hc, vc);
      if (hc == HTOT - 1 && m_line_ok[0])
        $display("line frame=%0d v=%0d row=%0d shadow_a=%h shadow_b=%h",
                 frame, vc, m_row[0], m_shadow[0], m_shadow[1][3:0]);
      hc++;
      if (hc == HTOT) begin
        hc = 0;
        vc++;
        if (vc == VTOT) begin
          vc = 0;
          frame++;
        end
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
